uart_cmd_decoder: RTL
=====================

// Module: uart_cmd_decoder
// PURPOSE
//  Decodes ASCII command bytes from the UART receiver into dual-watch controls.
//  Sits between uart_rx and dualwatch_core.
//  Produces stretched button pulses (L/R/U/D) and latched mode levels (fmt/stpw/calib).
//  These OR with the board inputs upstream of the core.
//  Flags unknown bytes and, optionally, echoes accepted bytes to uart_tx.
// PARAMETERS
//  PULSE_CYCLES  4   cycles each button pulse stays high (>=1)
//  PCNT_W        3   width of pulse counter; must hold PULSE_CYCLES
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  rx_data     in   8  received byte, valid when rx_valid=1
//  rx_valid    in   1  one-cycle strobe from uart_rx
//  btnL        out  1  left button pulse
//  btnR        out  1  right button pulse
//  btnU        out  1  up button pulse
//  btnD        out  1  down button pulse
//  fmt_mode    out  1  1: HH.MM, 0: SS.mm
//  stpw_mode   out  1  1: stopwatch, 0: watch
//  calib_mode  out  1  1: watch calibration active
//  cmd_err     out  1  one-cycle strobe on unrecognised byte
//  tx_data     out  8  echo byte (CMD_ECHO_EN only, else 8'h00)
//  tx_start    out  1  one-cycle echo request (CMD_ECHO_EN only, else 0)
//  tx_busy     in   1  uart_tx busy; tx_start only issued when 0
// BEHAVIOUR
//  Reset: all outputs 0, pulse counter 0, echo FSM IDLE, echo buffer empty.
//  Decode occurs on the rx_valid cycle N. Matching is case-insensitive.
//  Button bytes 'L','R','U','D' (and lowercase):
//    - selected btn* high on cycles N+1 .. N+PULSE_CYCLES.
//    - at most one btn* high at any time.
//  Button while a pulse is active:
//    - current pulse ends at N+1.
//    - new pulse starts at N+1 with a full PULSE_CYCLES count (restart, no queue).
//  Mode bytes (new value visible at N+1):
//    - 'F' toggles fmt_mode.
//    - 'M' toggles stpw_mode and forces calib_mode=0.
//    - 'C' toggles calib_mode only when stpw_mode=0; otherwise ignored (no cmd_err).
//  Mode byte during a button pulse: the pulse continues unaffected.
//  Byte 'X': clears fmt/stpw/calib to 0 and truncates any pulse at N+1.
//  8'h0D, 8'h0A, 8'h20: ignored silently (no err, no echo).
//  Any other byte: cmd_err=1 at N+1 for one cycle; no state change.
//  rx_valid with rst=1: byte discarded; reset wins.
//  Pulse counter decrements to 0 and never wraps; PULSE_CYCLES=1 gives a single-cycle pulse.
// CONFIGURATION
//  CMD_ECHO_EN defined:
//    - Each accepted byte (buttons, F/M/C/X, including ignored 'C') is echoed.
//    - Unknown bytes echo '?' (8'h3F).
//    - Echo FSM has states IDLE and HOLD, with a 1-entry buffer.
//    - IDLE: byte to echo and tx_busy=0 -> tx_start=1 at N+1 with tx_data=byte.
//    - IDLE: tx_busy=1 -> store byte, go to HOLD.
//    - HOLD: first cycle with tx_busy=0 -> tx_start, return to IDLE.
//    - New echo arriving in HOLD overwrites the buffer (latest wins).
//  CMD_ECHO_EN undefined: tx_start=0, tx_data=0 permanently; no echo FSM logic.
// TESTING
//  1. Reset then send 'R' -> btnR high exactly 4 cycles, starting 1 cycle after rx_valid; other btn*=0.
//  2. Send 'l' then 'U' 2 cycles later -> btnL high 2 cycles, then btnU high 4 cycles; no overlap.
//  3. Send 'M','C' -> stpw_mode=1, calib_mode stays 0. Then send 'M','C' -> stpw_mode=0, calib_mode=1.
//     Then send 'X' -> all modes 0.
//  4. Send 8'h51 'Q' -> cmd_err one cycle, modes unchanged. Send 8'h0D -> no cmd_err.
//  5. Assert rst on the same cycle as rx_valid('F') -> fmt_mode=0; all outputs 0 the next cycle.
//  6. CMD_ECHO_EN, tx_busy=1, send 'F' then 'D' -> after tx_busy falls, one tx_start with tx_data=8'h44.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: UART bytes -> stretched button pulses and latched mode levels.
// Define CMD_ECHO_EN to echo accepted bytes (unknown bytes as '?') to uart_tx.
module uart_cmd_decoder #(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned PCNT_W       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       btnL,
   output logic       btnR,
   output logic       btnU,
   output logic       btnD,
   output logic       fmt_mode,
   output logic       stpw_mode,
   output logic       calib_mode,
   output logic       cmd_err,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy
);

   localparam logic [7:0] ChL = 8'h4C;
   localparam logic [7:0] ChR = 8'h52;
   localparam logic [7:0] ChU = 8'h55;
   localparam logic [7:0] ChD = 8'h44;
   localparam logic [7:0] ChF = 8'h46;
   localparam logic [7:0] ChM = 8'h4D;
   localparam logic [7:0] ChC = 8'h43;
   localparam logic [7:0] ChX = 8'h58;
   localparam logic [7:0] ChCr = 8'h0D;
   localparam logic [7:0] ChLf = 8'h0A;
   localparam logic [7:0] ChSp = 8'h20;

   typedef enum logic [1:0] {BtnL, BtnR, BtnU, BtnD} btn_e;

   logic [7:0]        ch;
   logic              is_btn, is_f, is_m, is_c, is_x, is_unk;
   btn_e              btn_new;
   btn_e              btn_q, btn_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic              fmt_q, fmt_d, stpw_q, stpw_d, calib_q, calib_d, err_q, err_d;
   logic              pulse_on;

   // Fold lowercase letters onto uppercase; other bytes pass through unchanged.
   always_comb begin
      ch = rx_data;
      if (rx_data >= 8'h61 && rx_data <= 8'h7A) ch = rx_data - 8'h20;
   end

   always_comb begin
      is_btn  = 1'b0;
      is_f    = 1'b0;
      is_m    = 1'b0;
      is_c    = 1'b0;
      is_x    = 1'b0;
      is_unk  = 1'b0;
      btn_new = BtnL;
      case (ch)
         ChL: begin is_btn = 1'b1; btn_new = BtnL; end
         ChR: begin is_btn = 1'b1; btn_new = BtnR; end
         ChU: begin is_btn = 1'b1; btn_new = BtnU; end
         ChD: begin is_btn = 1'b1; btn_new = BtnD; end
         ChF: is_f = 1'b1;
         ChM: is_m = 1'b1;
         ChC: is_c = 1'b1;
         ChX: is_x = 1'b1;
         ChCr, ChLf, ChSp: ;
         default: is_unk = 1'b1;
      endcase
   end

   always_comb begin
      btn_d   = btn_q;
      pcnt_d  = pcnt_q;
      fmt_d   = fmt_q;
      stpw_d  = stpw_q;
      calib_d = calib_q;
      err_d   = 1'b0;
      if (pcnt_q != '0) pcnt_d = pcnt_q - PCNT_W'(1);
      if (rx_valid) begin
         // A new button restarts the pulse with a full count rather than queueing.
         if (is_btn) begin
            btn_d  = btn_new;
            pcnt_d = PCNT_W'(PULSE_CYCLES);
         end
         if (is_f) fmt_d = ~fmt_q;
         if (is_m) begin
            stpw_d  = ~stpw_q;
            calib_d = 1'b0;
         end
         if (is_c && !stpw_q) calib_d = ~calib_q;
         if (is_x) begin
            fmt_d   = 1'b0;
            stpw_d  = 1'b0;
            calib_d = 1'b0;
            pcnt_d  = '0;
         end
         if (is_unk) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q   <= BtnL;
         pcnt_q  <= '0;
         fmt_q   <= 1'b0;
         stpw_q  <= 1'b0;
         calib_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         btn_q   <= btn_d;
         pcnt_q  <= pcnt_d;
         fmt_q   <= fmt_d;
         stpw_q  <= stpw_d;
         calib_q <= calib_d;
         err_q   <= err_d;
      end
   end

   assign pulse_on   = (pcnt_q != '0);
   assign btnL       = pulse_on && (btn_q == BtnL);
   assign btnR       = pulse_on && (btn_q == BtnR);
   assign btnU       = pulse_on && (btn_q == BtnU);
   assign btnD       = pulse_on && (btn_q == BtnD);
   assign fmt_mode   = fmt_q;
   assign stpw_mode  = stpw_q;
   assign calib_mode = calib_q;
   assign cmd_err    = err_q;

`ifdef CMD_ECHO_EN
   typedef enum logic [0:0] {StIdle, StHold} echo_st_e;

   echo_st_e   st_q, st_d;
   logic [7:0] hold_q, hold_d, txd_q, txd_d;
   logic       txs_q, txs_d;
   logic       is_ign, echo_req;
   logic [7:0] echo_byte;

   assign is_ign    = (rx_data == ChCr) || (rx_data == ChLf) || (rx_data == ChSp);
   assign echo_req  = rx_valid && !is_ign;
   assign echo_byte = is_unk ? 8'h3F : rx_data;

   always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      txd_d  = txd_q;
      txs_d  = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (echo_req) begin
               if (!tx_busy) begin
                  txs_d = 1'b1;
                  txd_d = echo_byte;
               end else begin
                  hold_d = echo_byte;
                  st_d   = StHold;
               end
            end
         end
         StHold: begin
            // Latest echo wins, even one arriving on the cycle the buffer drains.
            if (!tx_busy) begin
               txs_d = 1'b1;
               txd_d = echo_req ? echo_byte : hold_q;
               st_d  = StIdle;
            end else if (echo_req) begin
               hold_d = echo_byte;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= StIdle;
         hold_q <= 8'h00;
         txd_q  <= 8'h00;
         txs_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         hold_q <= hold_d;
         txd_q  <= txd_d;
         txs_q  <= txs_d;
      end
   end

   assign tx_start = txs_q;
   assign tx_data  = txd_q;
`else
   logic unused_tx_busy;
   assign unused_tx_busy = tx_busy;
   assign tx_start       = 1'b0;
   assign tx_data        = 8'h00;
`endif

endmodule
